// File: rtl/rr_arbiter8_pkg.sv
// Shared widths, FSM state encoding and the rotating-priority pick used by
// the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // First set request bit found scanning ptr, ptr+1, ... with 3-bit wrap.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        logic             found;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter8_if;
    import rr_arbiter8_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             timeout;

    modport slave  (input req, done, output gnt, gnt_idx, gnt_vld, timeout);
    modport master (output req, done, input gnt, gnt_idx, gnt_vld, timeout);

endinterface

// File: rtl/dec3to8_shift.sv
// Shift-style 3-to-8 decoder with enable; output is zero when disabled.
module dec3to8_shift
    import rr_arbiter8_pkg::*;
(
    input  logic [IDX_W-1:0] in,
    input  logic             en,
    output logic [N_REQ-1:0] out
);

    assign out = en ? (N_REQ'(1) << in) : '0;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with hold-time limit and forced-release pulse.
// state    | meaning
// ST_IDLE  | no grant; bubble after a release, or waiting for any request
// ST_GRANT | gnt_idx owns the resource; hold_cnt counts its grant cycles
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input logic         clk,
    input logic         rst,
    rr_arbiter8_if.slave bus
);

    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    // With the limit disabled the counter just saturates at all-ones.
    localparam logic [HW-1:0] HOLD_LIM = (MAX_HOLD == 0) ? '1 : HW'(MAX_HOLD);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             vld_q, vld_d;
    logic             to_q, to_d;
    logic             cur_req;
    logic             lim_hit;
    logic             release_now;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        vld_d       = vld_q;
        to_d        = 1'b0;
        cur_req     = bus.req[idx_q];
        lim_hit     = (MAX_HOLD != 0) && (hold_q == HOLD_LIM);
        release_now = bus.done || !cur_req || lim_hit;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    idx_d   = rr_pick(bus.req, ptr_q);
                    vld_d   = 1'b1;
                    hold_d  = HW'(1);
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    state_d = ST_IDLE;
                    vld_d   = 1'b0;
                    hold_d  = '0;
                    ptr_d   = idx_q + IDX_W'(1);
                    // Pulse only when the limit is the sole reason for release.
                    to_d    = lim_hit && !bus.done && cur_req;
                end else if (hold_q != HOLD_LIM) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            vld_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            vld_q   <= vld_d;
            to_q    <= to_d;
        end
    end

    assign bus.gnt_idx = idx_q;
    assign bus.gnt_vld = vld_q;
    assign bus.timeout = to_q;

    dec3to8_shift u_dec (
        .in  (idx_q),
        .en  (vld_q),
        .out (bus.gnt)
    );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: two instances (hold limit 15 and 4) driven with the same
// stimulus, each checked every cycle against an abstract round-robin model.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    rr_arbiter8_if b15 ();
    rr_arbiter8_if b4 ();

    assign b15.req  = req;
    assign b15.done = done;
    assign b4.req   = req;
    assign b4.done  = done;

    rr_arbiter8 #(.MAX_HOLD(15)) dut15 (.clk(clk), .rst(rst), .bus(b15));
    rr_arbiter8 #(.MAX_HOLD(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));

    always #5 clk = ~clk;

    // Reference model: who holds the resource, for how long, and where the scan starts.
    int m_hold_max[2] = '{15, 4};
    bit m_busy[2]     = '{0, 0};
    int m_idx[2]      = '{0, 0};
    int m_ptr[2]      = '{0, 0};
    int m_held[2]     = '{0, 0};
    bit m_to[2]       = '{0, 0};

    logic [7:0] a_gnt[2];
    logic [2:0] a_idx[2];
    logic       a_vld[2];
    logic       a_to[2];

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic       vld;
        logic [2:0] idx;
        logic       to;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int d);
        int  c;
        bit  lim;
        bit  found;
        if (rst) begin
            m_busy[d] = 0; m_idx[d] = 0; m_ptr[d] = 0; m_held[d] = 0; m_to[d] = 0;
        end else if (!m_busy[d]) begin
            m_to[d] = 0;
            if (req != 8'h00) begin
                found = 0;
                for (int k = 0; k < 8; k++) begin
                    c = (m_ptr[d] + k) % 8;
                    if (!found && req[c]) begin
                        m_idx[d] = c;
                        found    = 1;
                    end
                end
                m_busy[d] = 1;
                m_held[d] = 1;
            end
        end else begin
            lim = (m_hold_max[d] != 0) && (m_held[d] >= m_hold_max[d]);
            if (done || !req[m_idx[d]] || lim) begin
                m_to[d]   = lim && !done && req[m_idx[d]];
                m_busy[d] = 0;
                m_ptr[d]  = (m_idx[d] + 1) % 8;
                m_held[d] = 0;
            end else begin
                m_held[d] = m_held[d] + 1;
                m_to[d]   = 0;
            end
        end
    endtask

    task automatic check_dut(input int d);
        logic [7:0] exp_g;
        exp_g = m_busy[d] ? (8'd1 << m_idx[d]) : 8'd0;
        chk($sformatf("gnt[d%0d]", d), 32'(a_gnt[d]), 32'(exp_g));
        chk($sformatf("gnt_vld[d%0d]", d), 32'(a_vld[d]), 32'(m_busy[d]));
        chk($sformatf("gnt_idx[d%0d]", d), 32'(a_idx[d]), 32'(m_idx[d]));
        chk($sformatf("timeout[d%0d]", d), 32'(a_to[d]), 32'(m_to[d]));
        chk($sformatf("onehot0[d%0d]", d), 32'($onehot0(a_gnt[d])), 32'd1);
        if (a_vld[d] === 1'b1)
            chk($sformatf("decode[d%0d]", d), 32'(a_gnt[d]), 32'(8'd1 << a_idx[d]));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        a_gnt[0] = b15.gnt; a_idx[0] = b15.gnt_idx; a_vld[0] = b15.gnt_vld; a_to[0] = b15.timeout;
        a_gnt[1] = b4.gnt;  a_idx[1] = b4.gnt_idx;  a_vld[1] = b4.gnt_vld;  a_to[1] = b4.timeout;
        check_dut(0);
        check_dut(1);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 8'h00; done = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        // rst, req, done -> gnt, vld, idx, timeout (instance with limit 15)
        tbl[0] = '{1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[1] = '{1'b0, 8'h01, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0};
        tbl[2] = '{1'b0, 8'h01, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[4] = '{1'b0, 8'h01, 1'b1, 8'h01, 1'b1, 3'd0, 1'b0};
        tbl[5] = '{1'b0, 8'h01, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};

        for (int i = 0; i < 7; i++) begin
            rst = tbl[i].rst; req = tbl[i].req; done = tbl[i].done;
            cyc();
            chk($sformatf("tbl%0d_gnt", i), 32'(b15.gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_vld", i), 32'(b15.gnt_vld), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d_idx", i), 32'(b15.gnt_idx), 32'(tbl[i].idx));
            chk($sformatf("tbl%0d_to", i), 32'(b15.timeout), 32'(tbl[i].to));
        end

        // Round robin over all requesters, done in the second grant cycle.
        do_reset();
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            done = 1'b0;
            cyc();
            chk($sformatf("rr_order%0d", g), 32'(b15.gnt_idx), 32'(g % 8));
            chk($sformatf("rr_vld%0d", g), 32'(b15.gnt_vld), 32'd1);
            cyc();
            chk($sformatf("rr_hold%0d", g), 32'(b15.gnt), 32'(8'd1 << (g % 8)));
            done = 1'b1;
            cyc();
            chk($sformatf("rr_bubble%0d", g), 32'(b15.gnt), 32'd0);
        end
        done = 1'b0;

        // Wrap 7 -> 0, then skip from ptr 6.
        do_reset();
        req = 8'h80; cyc();
        chk("wrap_g7", 32'(b15.gnt_idx), 32'd7);
        done = 1'b1; cyc();
        req = 8'h81; done = 1'b0; cyc();
        chk("wrap_g0", 32'(b15.gnt_idx), 32'd0);
        done = 1'b1; cyc();
        done = 1'b0; cyc();
        chk("wrap_g7b", 32'(b15.gnt_idx), 32'd7);
        done = 1'b1; cyc();
        req = 8'h20; done = 1'b0; cyc();
        chk("skip_g5", 32'(b15.gnt_idx), 32'd5);
        done = 1'b1; cyc();
        req = 8'h24; done = 1'b0; cyc();
        chk("skip_g2", 32'(b15.gnt_idx), 32'd2);
        done = 1'b1; cyc();
        done = 1'b0; cyc();
        chk("skip_g5b", 32'(b15.gnt_idx), 32'd5);
        done = 1'b1; cyc();
        done = 1'b0;

        // Hold-limit timeout on the limit-4 instance.
        do_reset();
        req = 8'h0C;
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk($sformatf("to_hold%0d", c), 32'(b4.gnt), 32'h04);
            chk($sformatf("to_nopulse%0d", c), 32'(b4.timeout), 32'd0);
        end
        cyc();
        chk("to_pulse", 32'(b4.timeout), 32'd1);
        chk("to_bubble", 32'(b4.gnt), 32'd0);
        cyc();
        chk("to_next", 32'(b4.gnt), 32'h08);
        chk("to_pulse_end", 32'(b4.timeout), 32'd0);

        // Done coinciding with the limit: normal release.
        do_reset();
        req = 8'h0C;
        for (int c = 0; c < 4; c++) cyc();
        chk("td_hold4", 32'(b4.gnt), 32'h04);
        done = 1'b1; cyc();
        chk("td_nopulse", 32'(b4.timeout), 32'd0);
        chk("td_bubble", 32'(b4.gnt), 32'd0);
        done = 1'b0;

        // Request drop from requester 3; next scan must start at 4.
        do_reset();
        req = 8'h08; cyc();
        chk("drop_g3", 32'(b15.gnt_idx), 32'd3);
        cyc();
        req = 8'h00; cyc();
        chk("drop_bubble", 32'(b15.gnt), 32'd0);
        req = 8'hFF; cyc();
        chk("drop_ptr4", 32'(b15.gnt_idx), 32'd4);

        // Reset during a grant to 5.
        do_reset();
        req = 8'h20; cyc();
        chk("rst_g5", 32'(b15.gnt_idx), 32'd5);
        req = 8'hFF; cyc();
        rst = 1'b1; cyc();
        chk("rst_gnt0", 32'(b15.gnt), 32'd0);
        chk("rst_to0", 32'(b15.timeout), 32'd0);
        rst = 1'b0; cyc();
        chk("rst_first0", 32'(b15.gnt_idx), 32'd0);
        chk("rst_first_vld", 32'(b15.gnt_vld), 32'd1);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            done = ($urandom_range(0, 5) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
